// File: rtl/clk_switch_ctrl.sv
// Control-side sequencer for the glitch-free two-source clock mux.
// Drives the mux select and confirms the hand-over via synchronised gate enables.
module clk_switch_ctrl #(
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 64,
    parameter logic RESET_SEL      = 1'b1
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic req,
    input  logic req_sel,
    input  logic en1_status,
    input  logic en0_status,
    output logic sel_out,
    output logic busy,
    output logic done,
    output logic err,
    output logic req_drop,
    output logic cur_sel
);
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DRAIN, ARM} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync1, sync0;
    logic                   s1, s0, s_new, s_old;
    logic                   timeout, complete;
    logic                   sel_nxt, cur_nxt, busy_nxt;
    logic                   done_nxt, err_nxt, drop_nxt;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync0 <= '0;
        end else begin
            sync1 <= {sync1[SYNC_STAGES-2:0], en1_status};
            sync0 <= {sync0[SYNC_STAGES-2:0], en0_status};
        end
    end

    assign s1 = sync1[SYNC_STAGES-1];
    assign s0 = sync0[SYNC_STAGES-1];

    // sel_out already holds the target while a switch is in flight
    assign s_new = sel_out ? s1 : s0;
    assign s_old = sel_out ? s0 : s1;

    assign timeout  = (cnt == CNT_MAX);
    assign complete = (state == ARM) && s_new && !s_old;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_out;
        cur_nxt   = cur_sel;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = err;
        drop_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    err_nxt = 1'b0;
                    if (req_sel == cur_sel) begin
                        done_nxt = 1'b1;
                    end else begin
                        sel_nxt   = req_sel;
                        busy_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN, ARM: begin
                drop_nxt = req;
                cnt_nxt  = timeout ? cnt : cnt + 1'b1;
                // completion outranks a timeout seen in the same cycle
                if (complete) begin
                    done_nxt  = 1'b1;
                    cur_nxt   = sel_out;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (state == DRAIN && !s_old) begin
                    state_nxt = ARM;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_out  <= RESET_SEL;
            cur_sel  <= RESET_SEL;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            req_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel_out  <= sel_nxt;
            cur_sel  <= cur_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            req_drop <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: two timeout settings share one mux model.
// Outputs are compared every cycle against a behavioural reference.
module tb_clk_switch_ctrl;
    localparam int   SYNC = 2;
    localparam logic RS   = 1'b1;
    localparam int   TMO0 = 64;
    localparam int   TMO1 = 8;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       req_sel = 1'b0;
    logic       en1 = 1'b1;
    logic       en0 = 1'b0;
    logic [1:0] sel_out, busy, done, err, req_drop, cur_sel;

    clk_switch_ctrl #(
        .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO0), .RESET_SEL(RS)
    ) u_dut0 (
        .clk1(clk1), .rst_n(rst_n), .req(req), .req_sel(req_sel),
        .en1_status(en1), .en0_status(en0),
        .sel_out(sel_out[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .req_drop(req_drop[0]), .cur_sel(cur_sel[0])
    );

    clk_switch_ctrl #(
        .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO1), .RESET_SEL(RS)
    ) u_dut1 (
        .clk1(clk1), .rst_n(rst_n), .req(req), .req_sel(req_sel),
        .en1_status(en1), .en0_status(en0),
        .sel_out(sel_out[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .req_drop(req_drop[1]), .cur_sel(cur_sel[1])
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;

    bit m_sel[2], m_cur[2], m_busy[2], m_done[2];
    bit m_err[2], m_drop[2], m_drained[2];
    int m_el[2];
    int tmo[2] = '{TMO0, TMO1};
    logic h1[$], h0[$];

    int   d_drop = 0;
    int   d_rise = 0;
    bit   stuck = 1'b0;
    bit   rnd = 1'b0;
    logic msel = 1'b1;
    int   since = 1000;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = RS;
            m_cur[i] = RS;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_err[i] = 1'b0;
            m_drop[i] = 1'b0;
            m_drained[i] = 1'b0;
            m_el[i] = 0;
        end
        h1.delete();
        h0.delete();
        for (int k = 0; k < SYNC; k++) begin
            h1.push_back(1'b0);
            h0.push_back(1'b0);
        end
    endfunction

    // one clk1 edge: status seen is the value sampled SYNC edges earlier
    function automatic void model_edge(input logic r, input logic rs,
                                       input logic e1, input logic e0);
        logic s1, s0, sn, so;
        s1 = h1.pop_front();
        s0 = h0.pop_front();
        h1.push_back(e1);
        h0.push_back(e0);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            m_drop[i] = 1'b0;
            if (!m_busy[i]) begin
                if (r) begin
                    m_err[i] = 1'b0;
                    if (rs == m_cur[i]) begin
                        m_done[i] = 1'b1;
                    end else begin
                        m_sel[i] = rs;
                        m_busy[i] = 1'b1;
                        m_drained[i] = 1'b0;
                        m_el[i] = 0;
                    end
                end
            end else begin
                m_drop[i] = r;
                sn = m_sel[i] ? s1 : s0;
                so = m_sel[i] ? s0 : s1;
                if (m_drained[i] && sn && !so) begin
                    m_done[i] = 1'b1;
                    m_cur[i] = m_sel[i];
                    m_busy[i] = 1'b0;
                end else if (m_el[i] >= tmo[i]) begin
                    m_err[i] = 1'b1;
                    m_busy[i] = 1'b0;
                end else begin
                    if (!so) m_drained[i] = 1'b1;
                    m_el[i]++;
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sel_out[%0d]", i), sel_out[i], m_sel[i]);
            chk($sformatf("cur_sel[%0d]", i), cur_sel[i], m_cur[i]);
            chk($sformatf("busy[%0d]", i), busy[i], m_busy[i]);
            chk($sformatf("done[%0d]", i), done[i], m_done[i]);
            chk($sformatf("err[%0d]", i), err[i], m_err[i]);
            chk($sformatf("req_drop[%0d]", i), req_drop[i], m_drop[i]);
        end
    endtask

    // mux model: old gate drops d_drop cycles after select moves,
    // new gate opens d_rise cycles later unless stuck
    task automatic mux_tick();
        if (sel_out[0] !== msel) begin
            msel = sel_out[0];
            since = 0;
            if (rnd) begin
                d_drop = $urandom_range(0, 4);
                d_rise = $urandom_range(0, 6);
                stuck = ($urandom_range(0, 7) == 0);
            end
        end else if (since < 1000) begin
            since++;
        end
        if (since >= d_drop) begin
            if (msel) en0 = 1'b0;
            else en1 = 1'b0;
        end
        if (!stuck && since >= d_drop + d_rise) begin
            if (msel) en1 = 1'b1;
            else en0 = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic rs);
        req = r;
        req_sel = rs;
        @(posedge clk1);
        model_edge(r, rs, en1, en0);
        #1;
        compare_all();
        mux_tick();
        req = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy != 2'b00) && n < lim) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sel0", sel_out[0], RS);
        chk("rst_sel1", sel_out[1], RS);
        chk("rst_cur0", cur_sel[0], RS);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_drop", req_drop, 0);
        model_reset();
        @(posedge clk1);
        #1;
        compare_all();
        mux_tick();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        chk("t1_sel", sel_out[0], 1);
        chk("t1_cur", cur_sel[0], 1);
        chk("t1_busy", busy[0], 0);
        chk("t1_err", err[0], 0);
        chk("t1_done", done[0], 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        d_drop = 3;
        d_rise = 4;
        step(1'b1, 1'b0);
        chk("t2_sel", sel_out[0], 0);
        chk("t2_busy", busy[0], 1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("t3_drop", req_drop[0], 1);
        chk("t3_hold", sel_out[0], 0);
        n = 0;
        while (!done[0] && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t2_done", done[0], 1);
        chk("t2_cur", cur_sel[0], 0);
        chk("t2_idle", busy[0], 0);
        step(1'b0, 1'b0);
        chk("t2_pulse", done[0], 0);

        step(1'b1, 1'b0);
        chk("t3_done", done[0], 1);
        chk("t3_sel", sel_out[0], 0);
        chk("t3_busy", busy[0], 0);
        wait_idle(20);

        stuck = 1'b1;
        d_drop = 0;
        d_rise = 0;
        step(1'b1, 1'b1);
        chk("t4_sel", sel_out[1], 1);
        n = 0;
        while (!err[1] && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t4_lat", n, 9);
        chk("t4_busy", busy[1], 0);
        chk("t4_cur", cur_sel[1], 0);
        chk("t4_keep", sel_out[1], 1);
        n = 0;
        while (busy[0] && n < 80) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t4_err0", err[0], 1);
        chk("t4_cur0", cur_sel[0], 0);
        stuck = 1'b0;
        step(1'b1, 1'b1);
        chk("t4_clr0", err[0], 0);
        chk("t4_clr1", err[1], 0);
        wait_idle(20);

        d_drop = 0;
        d_rise = 6;
        step(1'b1, 1'b0);
        n = 0;
        while (!done[1] && !err[1] && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t5_lat", n, 9);
        chk("t5_done", done[1], 1);
        chk("t5_err", err[1], 0);
        wait_idle(80);

        d_drop = 0;
        d_rise = 20;
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        chk("t6_busy", busy[0], 1);
        pulse_reset();
        d_rise = 1;
        step(1'b1, 1'b0);
        n = 0;
        while (!done[0] && n < 30) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("t6_done", done[0], 1);
        chk("t6_cur", cur_sel[0], 0);
        chk("t6_err", err[0], 0);
        wait_idle(30);

        rnd = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        stuck = 1'b0;
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
